// File: rtl/uart_tx_fifo.sv
// Byte queue in front of a UART transmitter; a 3-state drain engine hands one byte at a time to the UART.
// Latency: a byte written into an empty, idle queue shows up as tx_start two cycles after the write cycle.
// Backpressure: writes while full are dropped (sticky overflow); draining waits for tx_busy to rise and fall per byte.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   wr_en, wr_data    write strobe and byte to queue (one byte per cycle)
//   flush             discard all queued bytes (in-flight byte still completes)
//   tx_busy           busy flag from the downstream transmitter
//   tx_start, tx_data one-cycle start request and the byte it carries (held until next pop)
//   full, empty       count == DEPTH / count == 0
//   count             number of queued bytes
//   overflow          sticky: at least one write was dropped since reset/flush
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          flush,
   input  logic          tx_busy,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow
);

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } drain_state_t;

   drain_state_t state_q;
   drain_state_t state_d;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_accept;
   logic          wr_drop;
   logic          pop;

   // Status flags come straight from the count register so they always agree with it.
   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);

   // full is the registered value: a write while full is dropped even if a pop frees a slot this cycle.
   assign wr_accept = wr_en && !full && !flush;
   assign wr_drop   = wr_en &&  full && !flush;

   // Drain engine: pop only from IDLE, then wait for the transmitter to acknowledge (busy rises)
   // and finish (busy falls) before the next byte may be popped.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty && !tx_busy && !flush) begin
               pop     = 1'b1;
               state_d = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Engine state and transmitter outputs; flush never touches these, so a handed-off byte completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         state_q  <= state_d;
         tx_start <= pop;
         if (pop) begin
            tx_data <= mem[rd_ptr];
         end
      end
   end

   // Queue bookkeeping; pop and wr_accept are already suppressed during flush.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (wr_drop) begin
            overflow <= 1'b1;
         end
         case ({wr_accept, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_accept && !rst) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model plus a behavioural transmitter.
// Latency: inputs change 1 time unit after the rising edge, outputs are sampled there too.
// Backpressure: the transmitter model drives tx_busy (held, fixed 10-cycle or random length).
module tb_uart_tx_fifo;

   localparam int DEPTH    = 16;
   localparam int AW       = 4;
   localparam int M_MANUAL = 0;
   localparam int M_FIXED  = 1;
   localparam int M_RANDOM = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          flush = 1'b0;
   logic          tx_busy = 1'b0;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .flush    (flush),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference model: the queue contents, the sticky overflow flag and the last byte handed out.
   logic [7:0]  exp_q[$];
   logic [7:0]  tx_log[$];
   logic        m_ovf = 1'b0;
   logic [7:0]  m_data = 8'h00;
   // Transfer bookkeeping: a new start is legal only after busy has been seen high then low.
   bit          xfer_done = 1'b1;
   bit          seen_busy = 1'b0;
   // Transmitter model.
   int          mode = M_MANUAL;
   bit          man_busy = 1'b0;
   int          left = 0;
   int          pend = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample after the edge, advance the model with the inputs that edge saw,
   // compare every output, then drive tx_busy for the next edge.
   task automatic step();
      bit s;
      int size_before;
      @(posedge clk);
      #1;
      s           = tx_start;
      size_before = exp_q.size();
      if (rst) begin
         exp_q.delete();
         m_ovf     = 1'b0;
         m_data    = 8'h00;
         xfer_done = 1'b1;
         seen_busy = 1'b0;
         left      = 0;
         pend      = 0;
         check("rst_tx_start", tx_start, 0);
      end else begin
         if (s) begin
            check("start_not_busy", tx_busy, 0);
            check("start_after_done", xfer_done, 1);
            check("start_not_flushed", flush, 0);
            check("pop_nonempty", size_before != 0, 1);
            if (exp_q.size() != 0) begin
               m_data = exp_q.pop_front();
            end
            tx_log.push_back(tx_data);
            xfer_done = 1'b0;
            seen_busy = 1'b0;
         end else if (tx_busy) begin
            seen_busy = 1'b1;
         end else if (seen_busy) begin
            xfer_done = 1'b1;
         end
         if (flush) begin
            exp_q.delete();
            m_ovf = 1'b0;
         end else if (wr_en) begin
            if (size_before >= DEPTH) m_ovf = 1'b1;
            else exp_q.push_back(wr_data);
         end
      end
      check("tx_data", tx_data, m_data);
      check("count", count, exp_q.size());
      check("empty", empty, exp_q.size() == 0);
      check("full", full, exp_q.size() == DEPTH);
      check("overflow", overflow, m_ovf);

      if (mode == M_MANUAL) begin
         tx_busy = man_busy;
      end else begin
         if (s && !rst) begin
            pend = (mode == M_RANDOM) ? int'($urandom_range(0, 2)) : 0;
            left = (mode == M_RANDOM) ? int'($urandom_range(1, 6)) : 10;
         end
         if (left > 0) begin
            if (pend > 0) begin
               pend--;
               tx_busy = 1'b0;
            end else begin
               tx_busy = 1'b1;
               left--;
            end
         end else begin
            tx_busy = 1'b0;
         end
      end
   endtask

   task automatic write_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         if (exp_q.size() == 0 && xfer_done && left == 0 && !tx_busy) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      check("drain_in_time", ok, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      int n0;
      int cyc;

      // Reset
      rst = 1'b1;
      step();
      step();
      check("reset_tx_start", tx_start, 0);
      check("reset_tx_data", tx_data, 8'h00);
      check("reset_count", count, 0);
      check("reset_empty", empty, 1);
      check("reset_full", full, 0);
      check("reset_overflow", overflow, 0);
      rst = 1'b0;
      mode = M_FIXED;
      step();

      // Single byte latency
      tx_log.delete();
      write_byte(8'hA5);
      check("lat_c1_start", tx_start, 0);
      check("lat_c1_count", count, 1);
      step();
      check("lat_c2_start", tx_start, 1);
      check("lat_c2_data", tx_data, 8'hA5);
      check("lat_c2_count", count, 0);
      step();
      check("single_pulse", tx_start, 0);
      wait_drain(100);

      // Ordering with a 10-cycle busy transmitter
      tx_log.delete();
      write_byte(8'h01);
      write_byte(8'h02);
      write_byte(8'h03);
      wait_drain(200);
      check("order_len", tx_log.size(), 3);
      for (int k = 0; k < 3 && k < tx_log.size(); k++) begin
         check("order_byte", tx_log[k], k + 1);
      end

      // Full / overflow while the transmitter is held busy
      mode = M_MANUAL;
      man_busy = 1'b1;
      tx_busy = 1'b1;
      tx_log.delete();
      for (int k = 0; k <= DEPTH; k++) begin
         write_byte(8'h40 + 8'(k));
      end
      check("ovf_full", full, 1);
      check("ovf_count", count, DEPTH);
      check("ovf_flag", overflow, 1);
      mode = M_FIXED;
      man_busy = 1'b0;
      step();
      wait_drain(DEPTH * 20 + 50);
      check("ovf_drained", tx_log.size(), DEPTH);
      for (int k = 0; k < DEPTH && k < tx_log.size(); k++) begin
         check("ovf_byte", tx_log[k], 8'h40 + k);
      end

      // Wrap-around with random write gaps and random transmitter timing
      mode = M_RANDOM;
      tx_log.delete();
      i = 0;
      cyc = 0;
      while (i < 3 * DEPTH && cyc < 5000) begin
         if ($urandom_range(0, 3) != 0 && exp_q.size() < DEPTH) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            i++;
         end else begin
            wr_en = 1'b0;
         end
         step();
         cyc++;
      end
      wr_en = 1'b0;
      check("wrap_all_written", i, 3 * DEPTH);
      wait_drain(1000);
      check("wrap_len", tx_log.size(), 3 * DEPTH);
      for (int k = 0; k < 3 * DEPTH && k < tx_log.size(); k++) begin
         check("wrap_byte", tx_log[k], k);
      end

      // Flush mid-queue with one byte in flight
      mode = M_FIXED;
      step();
      for (int k = 0; k < 6; k++) begin
         write_byte(8'hC0 + 8'(k));
      end
      check("pre_flush_count", count, 5);
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      flush   = 1'b1;
      step();
      wr_en = 1'b0;
      flush = 1'b0;
      check("flush_count", count, 0);
      check("flush_empty", empty, 1);
      check("flush_overflow", overflow, 0);
      n0 = tx_log.size();
      for (int k = 0; k < 40; k++) step();
      check("flush_no_start", tx_log.size(), n0);
      check("flush_inflight_done", xfer_done, 1);

      // Reset in WAIT_BUSY with three bytes queued
      mode = M_MANUAL;
      man_busy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         write_byte(8'hD0 + 8'(k));
      end
      check("pre_rst_count", count, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_tx_start", tx_start, 0);
      check("mid_rst_tx_data", tx_data, 8'h00);
      check("mid_rst_count", count, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_overflow", overflow, 0);
      n0 = tx_log.size();
      for (int k = 0; k < 10; k++) step();
      check("post_rst_quiet", tx_log.size(), n0);
      mode = M_FIXED;
      write_byte(8'h5A);
      wait_drain(100);
      check("post_rst_len", tx_log.size(), n0 + 1);
      if (tx_log.size() == n0 + 1) begin
         check("post_rst_byte", tx_log[n0], 8'h5A);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
